kv_insert_engine: RTL and testbench

Write-side counterpart of the two-level hashed key/value lookup. The block accepts keys over a valid/ready handshake and writes each key into the key BRAM at the next free slot. It links the slot address into hash table 1 (key mod HASH1_SIZE) or, on collision, into hash table 2 (key mod HASH2_SIZE). It reports the slot address and an insert status per request; value address 0 means "empty entry", matching the lookup side's encoding.

---
 rtl/kv_insert_engine.sv | 156 +++++++++++++++
 tb/tb_kv_insert_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/kv_insert_engine.sv
// kv_insert_engine: write side of the two-level hashed key/value store.
// Keys land in the key RAM at the next free slot; the slot address is linked
// into table1 (key % HASH1_SIZE) or, if that bucket holds a different key,
// into table2 (key % HASH2_SIZE). Slot address 0 means "empty" in both tables.
module kv_insert_engine #(
  parameter int KEY_WIDTH  = 32,
  parameter int ADDR_BITS  = 4,
  parameter int HASH1_SIZE = 5,
  parameter int HASH2_SIZE = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [KEY_WIDTH-1:0] ins_key,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ADDR_BITS-1:0] resp_addr,
  output logic [1:0]           resp_status,
  output logic [ADDR_BITS-1:0] used_count
);

  localparam int H1W   = (HASH1_SIZE > 1) ? $clog2(HASH1_SIZE) : 1;
  localparam int H2W   = (HASH2_SIZE > 1) ? $clog2(HASH2_SIZE) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [3:0] {
    CLEAR, IDLE, RD_H1, CHK_H1, CMP_H1, CHK_H2, CMP_H2, WR, DONE
  } state_t;

  state_t               state;
  logic [H2W-1:0]       idx;
  logic [ADDR_BITS-1:0] next_free;
  logic [KEY_WIDTH-1:0] key_q;
  logic [H1W-1:0]       h1;
  logic [H2W-1:0]       h2;
  logic [ADDR_BITS-1:0] ent;    // registered table read data
  logic [KEY_WIDTH-1:0] kdat;   // registered key RAM read data
  logic                 tgt;    // 0: link into table1, 1: table2

  logic [KEY_WIDTH-1:0] key_ram [DEPTH];
  logic [ADDR_BITS-1:0] table1  [HASH1_SIZE];
  logic [ADDR_BITS-1:0] table2  [HASH2_SIZE];

  // Control FSM: sequences clear, probe of both tables, insert and response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= CLEAR;
      idx         <= '0;
      next_free   <= ADDR_BITS'(1);
      used_count  <= '0;
      ins_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_addr   <= '0;
      resp_status <= 2'b00;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == H2W'(HASH2_SIZE - 1)) begin
            state     <= IDLE;
            ins_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        IDLE: begin
          if (ins_valid) begin
            key_q     <= ins_key;
            h1        <= H1W'(ins_key % KEY_WIDTH'(HASH1_SIZE));
            h2        <= H2W'(ins_key % KEY_WIDTH'(HASH2_SIZE));
            ins_ready <= 1'b0;
            state     <= RD_H1;
          end
        end
        RD_H1: begin
          ent   <= table1[h1];
          state <= CHK_H1;
        end
        CHK_H1: begin
          if (ent == '0) begin
            tgt   <= 1'b0;
            state <= WR;
          end else begin
            kdat  <= key_ram[ent];
            state <= CMP_H1;
          end
        end
        CMP_H1: begin
          if (kdat == key_q) begin
            resp_addr   <= ent;
            resp_status <= 2'b10;
            resp_valid  <= 1'b1;
            state       <= DONE;
          end else begin
            ent   <= table2[h2];
            state <= CHK_H2;
          end
        end
        CHK_H2: begin
          if (ent == '0) begin
            tgt   <= 1'b1;
            state <= WR;
          end else begin
            kdat  <= key_ram[ent];
            state <= CMP_H2;
          end
        end
        CMP_H2: begin
          // Both buckets hold other keys: no third level, report full.
          resp_addr   <= (kdat == key_q) ? ent : '0;
          resp_status <= (kdat == key_q) ? 2'b10 : 2'b11;
          resp_valid  <= 1'b1;
          state       <= DONE;
        end
        WR: begin
          // next_free wraps to 0 once the last slot is used: RAM exhausted.
          if (next_free == '0) begin
            resp_addr   <= '0;
            resp_status <= 2'b11;
          end else begin
            resp_addr   <= next_free;
            resp_status <= {1'b0, tgt};
            next_free   <= next_free + 1'b1;
            used_count  <= used_count + 1'b1;
          end
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ins_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage writes: bucket clearing after reset, and the insert itself in WR.
  // Gated by reset_n so an aborted WR never leaves a half-linked entry.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        table2[idx] <= '0;
        if (32'(idx) < HASH1_SIZE) table1[H1W'(idx)] <= '0;
      end else if (state == WR && next_free != '0) begin
        key_ram[next_free] <= key_q;
        if (tgt) table2[h2] <= next_free;
        else     table1[h1] <= next_free;
      end
    end
  end

endmodule

// File: tb/tb_kv_insert_engine.sv
// Directed bench for kv_insert_engine: reset/clear timing, table1 and table2
// inserts, duplicates, full bucket, response backpressure, mid-op reset.
module tb_kv_insert_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [31:0] ins_key = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [3:0]  resp_addr;
  logic [1:0]  resp_status;
  logic [3:0]  used_count;

  int total = 0;
  int bad   = 0;

  kv_insert_engine #(.KEY_WIDTH(32), .ADDR_BITS(4), .HASH1_SIZE(5), .HASH2_SIZE(10)) dut (
    .clock(clock), .reset_n(reset_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_key(ins_key), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_addr(resp_addr), .resp_status(resp_status), .used_count(used_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_insert(input logic [31:0] key);
    int n = 0;
    while (!ins_ready && n < 40) begin @(negedge clock); n++; end
    if (!ins_ready) begin
      total++; bad++;
      $display("FAIL ready_wait got=%b want=1", ins_ready);
    end
    ins_valid = 1'b1; ins_key = key;
    @(posedge clock); @(negedge clock);
    ins_valid = 1'b0;
  endtask

  // Edges after the accept edge until resp_valid is seen; 99 on timeout.
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(posedge clock); lat++; @(negedge clock);
    end while (!resp_valid && lat < 20);
    if (!resp_valid) lat = 99;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if ({ins_ready, resp_valid, resp_addr, resp_status, used_count} !== 12'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {ins_ready, resp_valid, resp_addr, resp_status, used_count});
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); @(negedge clock);
      total++; if (ins_ready !== (i == 10)) begin
        bad++; $display("FAIL clear_ready edge=%0d got=%b want=%b", i, ins_ready, (i == 10));
      end
      total++; if ({resp_valid, resp_addr, resp_status, used_count} !== 11'h0) begin
        bad++; $display("FAIL clear_outputs edge=%0d got=%h want=0", i, {resp_valid, resp_addr, resp_status, used_count});
      end
    end
  endtask

  task automatic test_table1_insert();
    int lat;
    start_insert(32'd7); wait_resp(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL t1_lat got=%0d want=3", lat); end
    total++; if (resp_status !== 2'b00) begin bad++; $display("FAIL t1_status got=%b want=00", resp_status); end
    total++; if (resp_addr !== 4'd1) begin bad++; $display("FAIL t1_addr got=%0d want=1", resp_addr); end
    total++; if (used_count !== 4'd1) begin bad++; $display("FAIL t1_used got=%0d want=1", used_count); end
    ack();
  endtask

  task automatic test_table2_and_dup();
    int lat;
    start_insert(32'd12); wait_resp(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL t2_lat got=%0d want=5", lat); end
    total++; if (resp_status !== 2'b01) begin bad++; $display("FAIL t2_status got=%b want=01", resp_status); end
    total++; if (resp_addr !== 4'd2) begin bad++; $display("FAIL t2_addr got=%0d want=2", resp_addr); end
    total++; if (used_count !== 4'd2) begin bad++; $display("FAIL t2_used got=%0d want=2", used_count); end
    ack();
    start_insert(32'd7); wait_resp(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL dup_lat got=%0d want=3", lat); end
    total++; if (resp_status !== 2'b10) begin bad++; $display("FAIL dup_status got=%b want=10", resp_status); end
    total++; if (resp_addr !== 4'd1) begin bad++; $display("FAIL dup_addr got=%0d want=1", resp_addr); end
    total++; if (used_count !== 4'd2) begin bad++; $display("FAIL dup_used got=%0d want=2", used_count); end
    ack();
  endtask

  task automatic test_full_bucket();
    int lat;
    start_insert(32'd17); wait_resp(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL k17_lat got=%0d want=5", lat); end
    total++; if (resp_status !== 2'b01) begin bad++; $display("FAIL k17_status got=%b want=01", resp_status); end
    total++; if (resp_addr !== 4'd3) begin bad++; $display("FAIL k17_addr got=%0d want=3", resp_addr); end
    ack();
    start_insert(32'd22); wait_resp(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL full_lat got=%0d want=5", lat); end
    total++; if (resp_status !== 2'b11) begin bad++; $display("FAIL full_status got=%b want=11", resp_status); end
    total++; if (resp_addr !== 4'd0) begin bad++; $display("FAIL full_addr got=%0d want=0", resp_addr); end
    total++; if (used_count !== 4'd3) begin bad++; $display("FAIL full_used got=%0d want=3", used_count); end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    start_insert(32'd7); wait_resp(lat);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ins_valid = 1'b1; ins_key = 32'd99; end
      @(posedge clock); @(negedge clock);
      ins_valid = 1'b0;
      total++; if ({resp_valid, resp_addr, resp_status} !== {1'b1, 4'd1, 2'b10}) begin
        bad++; $display("FAIL hold_resp cyc=%0d got=%b_%0d_%b want=1_1_10", i, resp_valid, resp_addr, resp_status);
      end
      total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b want=0", i, ins_ready); end
    end
    ack();
    total++; if (used_count !== 4'd3) begin bad++; $display("FAIL ignored_used got=%0d want=3", used_count); end
    // 99 must not have been stored: a real insert now lands fresh in table1.
    start_insert(32'd99); wait_resp(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL k99_lat got=%0d want=3", lat); end
    total++; if (resp_status !== 2'b00) begin bad++; $display("FAIL k99_status got=%b want=00", resp_status); end
    total++; if (resp_addr !== 4'd4) begin bad++; $display("FAIL k99_addr got=%0d want=4", resp_addr); end
    total++; if (used_count !== 4'd4) begin bad++; $display("FAIL k99_used got=%0d want=4", used_count); end
    ack();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    start_insert(32'd12);
    repeat (3) begin @(posedge clock); @(negedge clock); end  // now in CHK_H2
    reset_n = 1'b0;
    @(posedge clock); @(negedge clock);
    total++; if ({resp_valid, ins_ready, used_count} !== 6'h0) begin
      bad++; $display("FAIL midrst_outputs got=%h want=0", {resp_valid, ins_ready, used_count});
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); @(negedge clock);
      total++; if (ins_ready !== (i == 10)) begin
        bad++; $display("FAIL midrst_clear edge=%0d got=%b want=%b", i, ins_ready, (i == 10));
      end
    end
    start_insert(32'd7); wait_resp(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL post_lat got=%0d want=3", lat); end
    total++; if (resp_status !== 2'b00) begin bad++; $display("FAIL post_status got=%b want=00", resp_status); end
    total++; if (resp_addr !== 4'd1) begin bad++; $display("FAIL post_addr got=%0d want=1", resp_addr); end
    total++; if (used_count !== 4'd1) begin bad++; $display("FAIL post_used got=%0d want=1", used_count); end
    ack();
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_table1_insert();
    test_table2_and_dup();
    test_full_bucket();
    test_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
